// File: rtl/ctrl_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_sequencer
// Brief    : Hardwired Moore control unit for the 32-bit bus CPU. It steps
//            through fetch and execute one state per cycle and decodes every
//            datapath strobe from the current state and IR[31:27].
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_sequencer #(
    parameter int           MEM_WAIT = 1,        // cycles per memory read step (1..15)
    parameter logic [4:0]   ADD_OP   = 5'b00011  // ALU code for address/PC arithmetic
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] IR,
    input  logic        CON_ff_out,
    input  logic        stop,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        PCout,
    output logic        MDRout,
    output logic        ZHIout,
    output logic        ZLOout,
    output logic        HIout,
    output logic        Loout,
    output logic        InPortout,
    output logic        Cout,
    output logic        PCin,
    output logic        IRin,
    output logic        MARin,
    output logic        MDRin,
    output logic        Yin,
    output logic        Zin,
    output logic        HIin,
    output logic        Loin,
    output logic        OutPortin,
    output logic        CON_ff_in,
    output logic        IncPC,
    output logic        MDRread,
    output logic        WRen,
    output logic        ZLowSelect,
    output logic [4:0]  ALU_opcode,
    output logic        run,
    output logic        illegal
);

    typedef enum logic [3:0] {
        S_RST  = 4'd0,
        S_F0   = 4'd1,
        S_F1   = 4'd2,
        S_F2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_T7   = 4'd8,
        S_HALT = 4'd9
    } state_t;

    // Memory read steps count down from MEM_WAIT-1 to zero before advancing.
    localparam logic [3:0] C_WAIT_LOAD = 4'(MEM_WAIT - 1);

    state_t      state_q, state_d;
    logic [3:0]  wait_q, wait_d;
    state_t      w_next_fetch;

    logic [4:0]  w_op;
    logic        w_ld, w_ldi, w_st, w_alu, w_imm, w_muldiv, w_negnot, w_br;
    logic        w_jr, w_in, w_out, w_mfhi, w_mflo, w_nop, w_halt, w_undef;
    logic        w_one_step;
    logic        w_unused_ir;

    assign w_op        = IR[31:27];
    assign w_unused_ir = ^IR[26:0];   // register fields are routed by the datapath, not here

    assign w_ld       = (w_op == 5'd0);
    assign w_ldi      = (w_op == 5'd1);
    assign w_st       = (w_op == 5'd2);
    assign w_alu      = (w_op >= 5'd3)  && (w_op <= 5'd11);
    assign w_imm      = (w_op >= 5'd12) && (w_op <= 5'd14);
    assign w_muldiv   = (w_op == 5'd15) || (w_op == 5'd16);
    assign w_negnot   = (w_op == 5'd17) || (w_op == 5'd18);
    assign w_br       = (w_op == 5'd19);
    assign w_jr       = (w_op == 5'd20);
    assign w_in       = (w_op == 5'd22);
    assign w_out      = (w_op == 5'd23);
    assign w_mfhi     = (w_op == 5'd24);
    assign w_mflo     = (w_op == 5'd25);
    assign w_nop      = (w_op == 5'd26);
    assign w_halt     = (w_op == 5'd27);
    assign w_undef    = (w_op == 5'd21) || (w_op[4:2] == 3'b111);
    assign w_one_step = w_jr | w_in | w_out | w_mfhi | w_mflo | w_nop | w_undef;

    // A pending stop replaces the next fetch with HALT, so no fetch strobes fire.
    assign w_next_fetch = stop ? S_HALT : S_F0;

    // Next-state and wait-counter logic.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            S_RST: state_d = w_next_fetch;
            S_F0: begin
                state_d = S_F1;
                wait_d  = C_WAIT_LOAD;
            end
            S_F1: begin
                if (wait_q != 4'd0) wait_d  = wait_q - 4'd1;
                else                state_d = S_F2;
            end
            S_F2: state_d = S_T3;
            S_T3: begin
                if (w_halt)          state_d = S_HALT;
                else if (w_one_step) state_d = w_next_fetch;
                else                 state_d = S_T4;
            end
            S_T4: state_d = w_negnot ? w_next_fetch : S_T5;
            S_T5: begin
                if (w_ld) begin
                    state_d = S_T6;
                    wait_d  = C_WAIT_LOAD;
                end else if (w_st || w_muldiv || w_br) begin
                    state_d = S_T6;
                end else begin
                    state_d = w_next_fetch;
                end
            end
            S_T6: begin
                if (w_ld && (wait_q != 4'd0)) wait_d  = wait_q - 4'd1;
                else if (w_ld || w_st)        state_d = S_T7;
                else                          state_d = w_next_fetch;
            end
            S_T7:    state_d = w_next_fetch;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RST;
        endcase
    end

    // State and wait-counter registers; clr aborts to RST from any state.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_RST;
            wait_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Strobe decode from the current step and the latched opcode.
    always_comb begin
        {Gra, Grb, Grc, Rin, Rout, BAout}                                  = '0;
        {PCout, MDRout, ZHIout, ZLOout, HIout, Loout, InPortout, Cout}     = '0;
        {PCin, IRin, MARin, MDRin, Yin, Zin, HIin, Loin, OutPortin, CON_ff_in} = '0;
        {IncPC, MDRread, WRen}                                             = '0;
        ALU_opcode = ADD_OP;
        illegal    = 1'b0;
        run        = (state_q != S_RST) && (state_q != S_HALT);
        case (state_q)
            S_F0: {PCout, MARin, IncPC, Zin} = 4'b1111;
            S_F1: {ZLOout, PCin, MDRread, MDRin} = 4'b1111;
            S_F2: {MDRout, IRin} = 2'b11;
            S_T3: begin
                if (w_ld || w_ldi || w_st)  {Grb, BAout, Yin} = 3'b111;
                else if (w_alu || w_imm)    {Grb, Rout, Yin}  = 3'b111;
                else if (w_muldiv)          {Gra, Rout, Yin}  = 3'b111;
                else if (w_negnot) begin
                    {Grb, Rout, Zin} = 3'b111;
                    ALU_opcode       = w_op;
                end
                else if (w_br)   {Gra, Rout, CON_ff_in}  = 3'b111;
                else if (w_jr)   {Gra, Rout, PCin}       = 3'b111;
                else if (w_in)   {InPortout, Gra, Rin}   = 3'b111;
                else if (w_out)  {Gra, Rout, OutPortin}  = 3'b111;
                else if (w_mfhi) {HIout, Gra, Rin}       = 3'b111;
                else if (w_mflo) {Loout, Gra, Rin}       = 3'b111;
                else if (w_undef) illegal = 1'b1;
            end
            S_T4: begin
                if (w_ld || w_ldi || w_st) {Cout, Zin} = 2'b11;
                else if (w_imm) begin
                    {Cout, Zin} = 2'b11;
                    ALU_opcode  = w_op;
                end
                else if (w_alu) begin
                    {Grc, Rout, Zin} = 3'b111;
                    ALU_opcode       = w_op;
                end
                else if (w_muldiv) begin
                    {Grb, Rout, Zin} = 3'b111;
                    ALU_opcode       = w_op;
                end
                else if (w_negnot) {ZLOout, Gra, Rin} = 3'b111;
                else if (w_br)     {PCout, Yin}       = 2'b11;
            end
            S_T5: begin
                if (w_ld || w_st)                 {ZLOout, MARin}    = 2'b11;
                else if (w_ldi || w_alu || w_imm) {ZLOout, Gra, Rin} = 3'b111;
                else if (w_muldiv)                {ZLOout, Loin}     = 2'b11;
                else if (w_br)                    {Cout, Zin}        = 2'b11;
            end
            S_T6: begin
                if (w_ld)                    {MDRread, MDRin}    = 2'b11;
                else if (w_st)               {Gra, Rout, MDRin}  = 3'b111;
                else if (w_muldiv)           {ZHIout, HIin}      = 2'b11;
                else if (w_br && CON_ff_out) {ZLOout, PCin}      = 2'b11;
            end
            S_T7: begin
                if (w_ld)      {MDRout, Gra, Rin} = 3'b111;
                else if (w_st) WRen = 1'b1;
            end
            default: ;
        endcase
        ZLowSelect = ZLOout;
    end

endmodule
`default_nettype wire

// File: tb/tb_ctrl_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctrl_sequencer
// Brief    : Self-checking bench for ctrl_sequencer. Two instances (MEM_WAIT
//            1 and 3) share stimulus; a step-list model built from the
//            instruction table supplies the expected strobes per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ctrl_sequencer;

    localparam logic [4:0] ADD_OP = 5'b00011;

    // Strobe bit positions in the packed observation word.
    localparam logic [27:0] GRA = 28'd1 << 0,  GRB = 28'd1 << 1,  GRC = 28'd1 << 2;
    localparam logic [27:0] RIN = 28'd1 << 3,  ROUT = 28'd1 << 4, BAOUT = 28'd1 << 5;
    localparam logic [27:0] PCOUT = 28'd1 << 6, MDROUT = 28'd1 << 7, ZHIOUT = 28'd1 << 8;
    localparam logic [27:0] ZLOOUT = 28'd1 << 9, HIOUT = 28'd1 << 10, LOOUT = 28'd1 << 11;
    localparam logic [27:0] INPOUT = 28'd1 << 12, COUT = 28'd1 << 13, PCIN = 28'd1 << 14;
    localparam logic [27:0] IRIN = 28'd1 << 15, MARIN = 28'd1 << 16, MDRIN = 28'd1 << 17;
    localparam logic [27:0] YIN = 28'd1 << 18, ZIN = 28'd1 << 19, HIIN = 28'd1 << 20;
    localparam logic [27:0] LOIN = 28'd1 << 21, OUTPIN = 28'd1 << 22, CONIN = 28'd1 << 23;
    localparam logic [27:0] INCPC = 28'd1 << 24, MDRREAD = 28'd1 << 25, WREN = 28'd1 << 26;

    typedef struct packed {
        logic [27:0] s;
        logic [4:0]  alu;
        logic        run;
        logic        ill;
    } step_t;

    localparam step_t IDLE = {28'd0, ADD_OP, 1'b0, 1'b0};

    logic        clk, clr, CON_ff_out, stop, sel;
    logic [31:0] IR;
    logic [27:0] s1, s3;
    logic [4:0]  alu1, alu3;
    logic        run1, run3, ill1, ill3;

    step_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    ctrl_sequencer #(.MEM_WAIT(1), .ADD_OP(ADD_OP)) u_dut1 (
        .clk(clk), .clr(clr), .IR(IR), .CON_ff_out(CON_ff_out), .stop(stop),
        .Gra(s1[0]), .Grb(s1[1]), .Grc(s1[2]), .Rin(s1[3]), .Rout(s1[4]), .BAout(s1[5]),
        .PCout(s1[6]), .MDRout(s1[7]), .ZHIout(s1[8]), .ZLOout(s1[9]), .HIout(s1[10]),
        .Loout(s1[11]), .InPortout(s1[12]), .Cout(s1[13]), .PCin(s1[14]), .IRin(s1[15]),
        .MARin(s1[16]), .MDRin(s1[17]), .Yin(s1[18]), .Zin(s1[19]), .HIin(s1[20]),
        .Loin(s1[21]), .OutPortin(s1[22]), .CON_ff_in(s1[23]), .IncPC(s1[24]),
        .MDRread(s1[25]), .WRen(s1[26]), .ZLowSelect(s1[27]),
        .ALU_opcode(alu1), .run(run1), .illegal(ill1)
    );

    ctrl_sequencer #(.MEM_WAIT(3), .ADD_OP(ADD_OP)) u_dut3 (
        .clk(clk), .clr(clr), .IR(IR), .CON_ff_out(CON_ff_out), .stop(stop),
        .Gra(s3[0]), .Grb(s3[1]), .Grc(s3[2]), .Rin(s3[3]), .Rout(s3[4]), .BAout(s3[5]),
        .PCout(s3[6]), .MDRout(s3[7]), .ZHIout(s3[8]), .ZLOout(s3[9]), .HIout(s3[10]),
        .Loout(s3[11]), .InPortout(s3[12]), .Cout(s3[13]), .PCin(s3[14]), .IRin(s3[15]),
        .MARin(s3[16]), .MDRin(s3[17]), .Yin(s3[18]), .Zin(s3[19]), .HIin(s3[20]),
        .Loin(s3[21]), .OutPortin(s3[22]), .CON_ff_in(s3[23]), .IncPC(s3[24]),
        .MDRread(s3[25]), .WRen(s3[26]), .ZLowSelect(s3[27]),
        .ALU_opcode(alu3), .run(run3), .illegal(ill3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One executing step; ZLowSelect always accompanies ZLOout.
    function automatic step_t mk(input logic [27:0] m, input logic [4:0] alu, input logic ill);
        step_t t;
        logic [27:0] mm;
        mm = m;
        if (mm[9]) mm[27] = 1'b1;
        t.s = mm; t.alu = alu; t.run = 1'b1; t.ill = ill;
        return t;
    endfunction

    function automatic step_t pl(input logic [27:0] m);
        return mk(m, ADD_OP, 1'b0);
    endfunction

    // Expected per-cycle step list of one instruction, straight from the opcode table.
    task automatic push_instr(input logic [4:0] op, input logic con, input int mw);
        exp_q.push_back(pl(PCOUT | MARIN | INCPC | ZIN));
        repeat (mw) exp_q.push_back(pl(ZLOOUT | PCIN | MDRREAD | MDRIN));
        exp_q.push_back(pl(MDROUT | IRIN));
        if (op == 5'd0) begin
            exp_q.push_back(pl(GRB | BAOUT | YIN));
            exp_q.push_back(pl(COUT | ZIN));
            exp_q.push_back(pl(ZLOOUT | MARIN));
            repeat (mw) exp_q.push_back(pl(MDRREAD | MDRIN));
            exp_q.push_back(pl(MDROUT | GRA | RIN));
        end else if (op == 5'd1) begin
            exp_q.push_back(pl(GRB | BAOUT | YIN));
            exp_q.push_back(pl(COUT | ZIN));
            exp_q.push_back(pl(ZLOOUT | GRA | RIN));
        end else if (op == 5'd2) begin
            exp_q.push_back(pl(GRB | BAOUT | YIN));
            exp_q.push_back(pl(COUT | ZIN));
            exp_q.push_back(pl(ZLOOUT | MARIN));
            exp_q.push_back(pl(GRA | ROUT | MDRIN));
            exp_q.push_back(pl(WREN));
        end else if (op >= 5'd3 && op <= 5'd11) begin
            exp_q.push_back(pl(GRB | ROUT | YIN));
            exp_q.push_back(mk(GRC | ROUT | ZIN, op, 1'b0));
            exp_q.push_back(pl(ZLOOUT | GRA | RIN));
        end else if (op >= 5'd12 && op <= 5'd14) begin
            exp_q.push_back(pl(GRB | ROUT | YIN));
            exp_q.push_back(mk(COUT | ZIN, op, 1'b0));
            exp_q.push_back(pl(ZLOOUT | GRA | RIN));
        end else if (op == 5'd15 || op == 5'd16) begin
            exp_q.push_back(pl(GRA | ROUT | YIN));
            exp_q.push_back(mk(GRB | ROUT | ZIN, op, 1'b0));
            exp_q.push_back(pl(ZLOOUT | LOIN));
            exp_q.push_back(pl(ZHIOUT | HIIN));
        end else if (op == 5'd17 || op == 5'd18) begin
            exp_q.push_back(mk(GRB | ROUT | ZIN, op, 1'b0));
            exp_q.push_back(pl(ZLOOUT | GRA | RIN));
        end else if (op == 5'd19) begin
            exp_q.push_back(pl(GRA | ROUT | CONIN));
            exp_q.push_back(pl(PCOUT | YIN));
            exp_q.push_back(pl(COUT | ZIN));
            exp_q.push_back(pl(con ? (ZLOOUT | PCIN) : 28'd0));
        end else if (op == 5'd20) exp_q.push_back(pl(GRA | ROUT | PCIN));
        else if (op == 5'd22) exp_q.push_back(pl(INPOUT | GRA | RIN));
        else if (op == 5'd23) exp_q.push_back(pl(GRA | ROUT | OUTPIN));
        else if (op == 5'd24) exp_q.push_back(pl(HIOUT | GRA | RIN));
        else if (op == 5'd25) exp_q.push_back(pl(LOOUT | GRA | RIN));
        else if (op == 5'd26 || op == 5'd27) exp_q.push_back(pl(28'd0));
        else exp_q.push_back(mk(28'd0, ADD_OP, 1'b1));
    endtask

    // Compare the selected instance with the head of the expected list.
    task automatic check_cycle(input string tag);
        step_t e, o;
        e = exp_q.pop_front();
        o = sel ? {s3, alu3, run3, ill3} : {s1, alu1, run1, ill1};
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s t=%0t got s=%h alu=%b run=%b ill=%b exp s=%h alu=%b run=%b ill=%b",
                   tag, $time, o.s, o.alu, o.run, o.ill, e.s, e.alu, e.run, e.ill);
        end
        checks++;
        assert (($countones(o.s[13:6]) <= 1) && !(o.s[26] && o.s[25])) else begin
            errors++;
            $error("FAIL %s_invariant t=%0t got s=%h exp single bus driver, no WRen with MDRread",
                   tag, $time, o.s);
        end
    endtask

    task automatic release_reset(input string tag);
        repeat (2) begin
            @(negedge clk); exp_q.push_back(IDLE); check_cycle(tag);
        end
        @(posedge clk); #1; clr = 1'b1;
        @(negedge clk); exp_q.push_back(IDLE); check_cycle(tag);
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk); #3; clr = 1'b0;
        #1; exp_q.push_back(IDLE); check_cycle(tag);
        release_reset(tag);
    endtask

    task automatic hold_idle(input string tag, input int k);
        repeat (k) begin
            @(posedge clk); #1;
            @(negedge clk); exp_q.push_back(IDLE); check_cycle(tag);
        end
    endtask

    // Run one instruction: junk IR during fetch, real IR from T3 on.
    task automatic run_instr(input string tag, input logic [4:0] op, input logic con,
                             input int stop_on, input int drop_last);
        int mw, fl, n;
        logic [31:0] r, ir, junk;
        mw = sel ? 3 : 1;
        exp_q.delete();
        push_instr(op, con, mw);
        if (op == 5'd27 || stop_on >= 0) repeat (3) exp_q.push_back(IDLE);
        r  = $urandom();
        ir = {op, r[26:0]};
        fl = 2 + mw;
        n  = exp_q.size() - drop_last;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (i == 0) begin
                junk = $urandom();
                IR = junk;
                CON_ff_out = 1'($urandom_range(0, 1));
            end
            if (i == fl) begin
                IR = ir;
                CON_ff_out = con;
            end
            if (i == stop_on) stop = 1'b1;
            @(negedge clk); check_cycle(tag);
        end
    endtask

    task automatic st_abort(input string tag);
        run_instr(tag, 5'd2, 1'b0, -1, 1);
        @(posedge clk); #1; check_cycle(tag);           // T7 with WRen high
        #2; clr = 1'b0;
        #1; exp_q.push_back(IDLE); check_cycle(tag);    // same cycle, back in RST
        release_reset(tag);
    endtask

    task automatic random_run(input int k);
        logic [4:0] op;
        for (int i = 0; i < k; i++) begin
            op = 5'($urandom_range(0, 31));
            if (op == 5'd27) op = 5'd26;
            run_instr("random", op, 1'($urandom_range(0, 1)), -1, 0);
        end
    endtask

    initial begin
        clr = 1'b1; IR = 32'd0; CON_ff_out = 1'b0; stop = 1'b0; sel = 1'b0;
        #2 clr = 1'b0;
        #1 exp_q.push_back(IDLE); check_cycle("reset");
        release_reset("reset");

        // MEM_WAIT = 1
        run_instr("add", 5'd3, 1'b0, -1, 0);
        run_instr("ld_mw1", 5'd0, 1'b0, -1, 0);
        run_instr("br_false", 5'd19, 1'b0, -1, 0);
        run_instr("br_true", 5'd19, 1'b1, -1, 0);
        run_instr("mul", 5'd16, 1'b0, -1, 0);
        run_instr("not", 5'd18, 1'b0, -1, 0);
        run_instr("undef_10101", 5'd21, 1'b0, -1, 0);
        random_run(40);
        st_abort("st_abort");
        run_instr("add_stop", 5'd3, 1'b0, 4, 0);
        stop = 1'b0;
        hold_idle("halt_hold", 3);
        do_reset("reset_halt");
        run_instr("illegal", 5'd31, 1'b0, -1, 0);
        run_instr("after_illegal", 5'd26, 1'b0, -1, 0);

        // MEM_WAIT = 3
        sel = 1'b1;
        do_reset("reset_mw3");
        run_instr("ld_mw3", 5'd0, 1'b0, -1, 0);
        run_instr("st_mw3", 5'd2, 1'b0, -1, 0);
        random_run(30);
        run_instr("halt_op", 5'd27, 1'b0, -1, 0);
        hold_idle("halt_op_hold", 2);
        do_reset("reset_mw3_b");
        st_abort("st_abort_mw3");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
